sp_sync_ram_be: RTL and testbench

Parametrised successor to the team's single-port synchronous RAM. Adds separate write/read data buses, per-byte write enables, selectable read latency (1 or 2), an optional post-reset clear engine, a read-valid strobe and an out-of-range error flag. It sits wherever a small local scratch or register-file store is needed, behind a simple cs/we/oe request interface.

---
 rtl/sp_ram_pkg.sv | 12 +
 rtl/ram_rd_pipe.sv | 52 +++++
 rtl/sp_sync_ram_be.sv | 112 +++++++++++
 tb/tb_sp_sync_ram_be.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sp_ram_pkg.sv
// rtl/sp_ram_pkg.sv - shared types and helpers for the synchronous RAM family
package sp_ram_pkg;

  typedef enum logic {ST_CLEAR, ST_READY} state_e;

  localparam int LAT_MAX = 2;

  function automatic int be_width(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// rtl/ram_rd_pipe.sv - LATENCY-deep register chain for read {valid, err, data}
module ram_rd_pipe
  import sp_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  input  logic                  err_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  valid_o,
  output logic                  err_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  localparam int LAT = (LATENCY < 1) ? 1 : ((LATENCY > LAT_MAX) ? LAT_MAX : LATENCY);

  logic [LAT-1:0]        valid_q;
  logic [LAT-1:0]        err_q;
  logic [DATA_WIDTH-1:0] data_q [LAT];

  // Data stages load only alongside a valid token so the output holds its last value.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      err_q   <= '0;
      for (int i = 0; i < LAT; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= valid_i;
      err_q[0]   <= err_i;
      if (valid_i) begin
        data_q[0] <= data_i;
      end
      for (int i = 1; i < LAT; i++) begin
        valid_q[i] <= valid_q[i-1];
        err_q[i]   <= err_q[i-1];
        if (valid_q[i-1]) begin
          data_q[i] <= data_q[i-1];
        end
      end
    end
  end

  assign valid_o = valid_q[LAT-1];
  assign err_o   = err_q[LAT-1];
  assign data_o  = data_q[LAT-1];

endmodule

// File: rtl/sp_sync_ram_be.sv
// rtl/sp_sync_ram_be.sv - single-port byte-enable RAM with clear engine and read pipe
module sp_sync_ram_be
  import sp_ram_pkg::*;
#(
  parameter int ADDR_WIDTH     = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH          = 16,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cs,
  input  logic                            we,
  input  logic                            oe,
  input  logic [ADDR_WIDTH-1:0]           addr,
  input  logic [DATA_WIDTH-1:0]           wdata,
  input  logic [be_width(DATA_WIDTH)-1:0] be,
  output logic [DATA_WIDTH-1:0]           rdata,
  output logic                            rvalid,
  output logic                            err,
  output logic                            busy
);

  localparam int                    BW       = be_width(DATA_WIDTH);
  localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] CLR_LAST = ADDR_WIDTH'(DEPTH - 1);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_addr_q, clr_addr_d;
  logic                    clr_we;
  logic                    wr_err_q;
  logic                    in_range;
  logic                    req_wr;
  logic                    req_rd;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    pipe_err;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  // With DEPTH == 2**ADDR_WIDTH every address compares below DEPTH_W.
  assign in_range = ({1'b0, addr} < DEPTH_W);
  assign req_wr   = cs & we & ~busy;
  assign req_rd   = cs & oe & ~we & ~busy;

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    clr_we     = 1'b0;
    busy       = (state_q == ST_CLEAR);
    case (state_q)
      ST_CLEAR: begin
        clr_we     = 1'b1;
        clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
        if (clr_addr_q == CLR_LAST) begin
          state_d    = ST_READY;
          clr_addr_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      clr_addr_q <= '0;
      wr_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      wr_err_q   <= req_wr & ~in_range;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_we) begin
        mem[clr_addr_q] <= '0;
      end else if (req_wr && in_range) begin
        for (int b = 0; b < BW; b++) begin
          if (be[b]) begin
            mem[addr][8*b +: 8] <= wdata[8*b +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (in_range) begin
      rd_data = mem[addr];
    end
  end

  ram_rd_pipe #(
    .DATA_WIDTH(DATA_WIDTH),
    .LATENCY   (READ_LATENCY)
  ) u_rd_pipe (
    .clk_i  (clk),
    .rst_i  (rst),
    .valid_i(req_rd),
    .err_i  (req_rd & ~in_range),
    .data_i (rd_data),
    .valid_o(rvalid),
    .err_o  (pipe_err),
    .data_o (rdata)
  );

  assign err = pipe_err | wr_err_q;

endmodule

// File: tb/tb_sp_sync_ram_be.sv
// tb/tb_sp_sync_ram_be.sv - directed bench: dut0 DEPTH 16 latency 1, dut1 DEPTH 12 latency 2
module tb_sp_sync_ram_be;

  logic        clk = 1'b0;
  logic        rst, cs, we, oe;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] rdata0, rdata1;
  logic        rvalid0, rvalid1, err0, err1, busy0, busy1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sp_sync_ram_be #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .DEPTH(16), .READ_LATENCY(1),
                   .CLEAR_ON_RESET(1)) dut0 (
    .clk(clk), .rst(rst), .cs(cs), .we(we), .oe(oe), .addr(addr), .wdata(wdata),
    .be(be), .rdata(rdata0), .rvalid(rvalid0), .err(err0), .busy(busy0));

  sp_sync_ram_be #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .DEPTH(12), .READ_LATENCY(2),
                   .CLEAR_ON_RESET(1)) dut1 (
    .clk(clk), .rst(rst), .cs(cs), .we(we), .oe(oe), .addr(addr), .wdata(wdata),
    .be(be), .rdata(rdata1), .rvalid(rvalid1), .err(err1), .busy(busy1));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cs = 1'b0; we = 1'b0; oe = 1'b0; be = 4'h0; addr = 4'h0; wdata = 32'h0;
  endtask

  task automatic drive_wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
    cs = 1'b1; we = 1'b1; oe = 1'b0; addr = a; wdata = d; be = b;
  endtask

  task automatic drive_rd(input logic [3:0] a);
    cs = 1'b1; we = 1'b0; oe = 1'b1; addr = a; be = 4'h0;
  endtask

  task automatic test_reset();
    int n0, n1;
    idle();
    rst = 1'b1;
    step();
    step();
    checks++;
    if (rdata0 !== 32'h0 || rvalid0 !== 1'b0 || err0 !== 1'b0 || busy0 !== 1'b1) begin
      errors++;
      $display("FAIL reset_dut0 rdata=%h rvalid=%b err=%b busy=%b exp 0/0/0/1",
               rdata0, rvalid0, err0, busy0);
    end
    checks++;
    if (rdata1 !== 32'h0 || rvalid1 !== 1'b0 || err1 !== 1'b0 || busy1 !== 1'b1) begin
      errors++;
      $display("FAIL reset_dut1 rdata=%h rvalid=%b err=%b busy=%b exp 0/0/0/1",
               rdata1, rvalid1, err1, busy1);
    end
    rst = 1'b0;
    n0 = 0;
    n1 = 0;
    for (int k = 0; k < 24; k++) begin
      if (busy0) n0++;
      if (busy1) n1++;
      step();
    end
    checks++;
    if (n0 != 16) begin
      errors++;
      $display("FAIL clear_len_dut0 busy_cycles=%0d exp 16", n0);
    end
    checks++;
    if (n1 != 12) begin
      errors++;
      $display("FAIL clear_len_dut1 busy_cycles=%0d exp 12", n1);
    end
  endtask

  task automatic test_clear_readback();
    int bad0, bad1;
    bad0 = 0;
    bad1 = 0;
    for (int i = 0; i < 16; i++) begin
      drive_rd(4'(i));
      step();
      if (rvalid0 !== 1'b1 || rdata0 !== 32'h0 || err0 !== 1'b0) bad0++;
      if (i >= 1 && (rvalid1 !== 1'b1 || rdata1 !== 32'h0 || err1 !== (i - 1 >= 12))) bad1++;
    end
    idle();
    step();
    if (rvalid1 !== 1'b1 || rdata1 !== 32'h0 || err1 !== 1'b1) bad1++;
    checks++;
    if (bad0 != 0) begin
      errors++;
      $display("FAIL clear_read_dut0 bad_reads=%0d exp 0", bad0);
    end
    checks++;
    if (bad1 != 0) begin
      errors++;
      $display("FAIL clear_read_dut1 bad_reads=%0d exp 0", bad1);
    end
    step();
  endtask

  task automatic test_basic();
    drive_wr(4'd3, 32'h12345678, 4'hF);
    step();
    drive_rd(4'd3);
    step();
    checks++;
    if (rvalid0 !== 1'b1 || rdata0 !== 32'h12345678) begin
      errors++;
      $display("FAIL basic_dut0 rvalid=%b rdata=%h exp 1/12345678", rvalid0, rdata0);
    end
    checks++;
    if (rvalid1 !== 1'b0) begin
      errors++;
      $display("FAIL basic_dut1_early rvalid=%b exp 0", rvalid1);
    end
    idle();
    step();
    checks++;
    if (rvalid1 !== 1'b1 || rdata1 !== 32'h12345678 || rvalid0 !== 1'b0) begin
      errors++;
      $display("FAIL basic_dut1 rvalid1=%b rdata1=%h rvalid0=%b exp 1/12345678/0",
               rvalid1, rdata1, rvalid0);
    end
    step();
  endtask

  task automatic test_byte_enable();
    drive_wr(4'd5, 32'hAABBCCDD, 4'hF);
    step();
    drive_wr(4'd5, 32'h11223344, 4'b0101);
    step();
    drive_rd(4'd5);
    step();
    checks++;
    if (rvalid0 !== 1'b1 || rdata0 !== 32'hAA22CC44) begin
      errors++;
      $display("FAIL be_dut0 rvalid=%b rdata=%h exp 1/aa22cc44", rvalid0, rdata0);
    end
    idle();
    step();
    checks++;
    if (rvalid1 !== 1'b1 || rdata1 !== 32'hAA22CC44) begin
      errors++;
      $display("FAIL be_dut1 rvalid=%b rdata=%h exp 1/aa22cc44", rvalid1, rdata1);
    end
    drive_wr(4'd6, 32'hCAFEF00D, 4'h0);
    step();
    drive_rd(4'd6);
    step();
    checks++;
    if (rvalid0 !== 1'b1 || rdata0 !== 32'h0) begin
      errors++;
      $display("FAIL be_zero_dut0 rvalid=%b rdata=%h exp 1/00000000", rvalid0, rdata0);
    end
    idle();
    step();
    step();
  endtask

  task automatic test_back_to_back();
    drive_rd(4'd3);
    step();
    checks++;
    if (rvalid0 !== 1'b1 || rdata0 !== 32'h12345678) begin
      errors++;
      $display("FAIL b2b_0_dut0 rvalid=%b rdata=%h exp 1/12345678", rvalid0, rdata0);
    end
    drive_rd(4'd4);
    step();
    checks++;
    if (rvalid0 !== 1'b1 || rdata0 !== 32'h0 || rvalid1 !== 1'b1 || rdata1 !== 32'h12345678) begin
      errors++;
      $display("FAIL b2b_1 r0=%b d0=%h r1=%b d1=%h exp 1/0/1/12345678",
               rvalid0, rdata0, rvalid1, rdata1);
    end
    drive_rd(4'd5);
    step();
    checks++;
    if (rvalid0 !== 1'b1 || rdata0 !== 32'hAA22CC44 || rvalid1 !== 1'b1 || rdata1 !== 32'h0) begin
      errors++;
      $display("FAIL b2b_2 r0=%b d0=%h r1=%b d1=%h exp 1/aa22cc44/1/0",
               rvalid0, rdata0, rvalid1, rdata1);
    end
    cs = 1'b1; we = 1'b1; oe = 1'b1; addr = 4'd7; wdata = 32'h0F0F0F0F; be = 4'hF;
    step();
    checks++;
    if (rvalid0 !== 1'b0 || rvalid1 !== 1'b1 || rdata1 !== 32'hAA22CC44) begin
      errors++;
      $display("FAIL collide_0 r0=%b r1=%b d1=%h exp 0/1/aa22cc44", rvalid0, rvalid1, rdata1);
    end
    idle();
    step();
    checks++;
    if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin
      errors++;
      $display("FAIL collide_1 r0=%b r1=%b exp 0/0", rvalid0, rvalid1);
    end
    drive_rd(4'd7);
    step();
    checks++;
    if (rvalid0 !== 1'b1 || rdata0 !== 32'h0F0F0F0F) begin
      errors++;
      $display("FAIL collide_rd_dut0 rvalid=%b rdata=%h exp 1/0f0f0f0f", rvalid0, rdata0);
    end
    idle();
    step();
    checks++;
    if (rvalid1 !== 1'b1 || rdata1 !== 32'h0F0F0F0F || rvalid0 !== 1'b0 || rdata0 !== 32'h0F0F0F0F) begin
      errors++;
      $display("FAIL collide_rd_dut1 r1=%b d1=%h r0=%b d0=%h exp 1/0f0f0f0f/0/0f0f0f0f",
               rvalid1, rdata1, rvalid0, rdata0);
    end
    step();
  endtask

  task automatic test_out_of_range();
    drive_wr(4'd13, 32'hDEADBEEF, 4'hF);
    step();
    checks++;
    if (err1 !== 1'b1 || err0 !== 1'b0) begin
      errors++;
      $display("FAIL oor_wr_err err1=%b err0=%b exp 1/0", err1, err0);
    end
    drive_rd(4'd13);
    step();
    checks++;
    if (rvalid0 !== 1'b1 || rdata0 !== 32'hDEADBEEF || err0 !== 1'b0 || err1 !== 1'b0) begin
      errors++;
      $display("FAIL oor_rd_dut0 r0=%b d0=%h e0=%b e1=%b exp 1/deadbeef/0/0",
               rvalid0, rdata0, err0, err1);
    end
    drive_rd(4'd5);
    step();
    checks++;
    if (rvalid1 !== 1'b1 || err1 !== 1'b1 || rdata1 !== 32'h0) begin
      errors++;
      $display("FAIL oor_rd_dut1 rvalid=%b err=%b rdata=%h exp 1/1/0", rvalid1, err1, rdata1);
    end
    idle();
    step();
    checks++;
    if (rvalid1 !== 1'b1 || err1 !== 1'b0 || rdata1 !== 32'hAA22CC44) begin
      errors++;
      $display("FAIL oor_intact_dut1 rvalid=%b err=%b rdata=%h exp 1/0/aa22cc44",
               rvalid1, err1, rdata1);
    end
    step();
  endtask

  task automatic test_reset_mid_clear();
    int n0, n1, side;
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n0 = 0;
    n1 = 0;
    side = 0;
    for (int k = 0; k < 24; k++) begin
      if (busy0) n0++;
      if (busy1) n1++;
      if (rvalid0 || err0 || rvalid1 || err1) side++;
      if (k < 4) drive_wr(4'd2, 32'hFFFFFFFF, 4'hF);
      else idle();
      step();
    end
    checks++;
    if (n0 != 16) begin
      errors++;
      $display("FAIL restart_dut0 busy_cycles=%0d exp 16", n0);
    end
    checks++;
    if (n1 != 12) begin
      errors++;
      $display("FAIL restart_dut1 busy_cycles=%0d exp 12", n1);
    end
    checks++;
    if (side != 0) begin
      errors++;
      $display("FAIL busy_drop_side side_cycles=%0d exp 0", side);
    end
    drive_rd(4'd2);
    step();
    checks++;
    if (rvalid0 !== 1'b1 || rdata0 !== 32'h0) begin
      errors++;
      $display("FAIL busy_drop_dut0 rvalid=%b rdata=%h exp 1/00000000", rvalid0, rdata0);
    end
    idle();
    step();
    checks++;
    if (rvalid1 !== 1'b1 || rdata1 !== 32'h0) begin
      errors++;
      $display("FAIL busy_drop_dut1 rvalid=%b rdata=%h exp 1/00000000", rvalid1, rdata1);
    end
  endtask

  task automatic test_cs_low();
    cs = 1'b0; we = 1'b1; oe = 1'b1; addr = 4'd2; wdata = 32'h55AA55AA; be = 4'hF;
    step();
    we = 1'b0;
    step();
    checks++;
    if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0 || err0 !== 1'b0) begin
      errors++;
      $display("FAIL cs_low_quiet r0=%b r1=%b e0=%b exp 0/0/0", rvalid0, rvalid1, err0);
    end
    drive_rd(4'd2);
    step();
    checks++;
    if (rvalid0 !== 1'b1 || rdata0 !== 32'h0) begin
      errors++;
      $display("FAIL cs_low_nowrite rvalid=%b rdata=%h exp 1/00000000", rvalid0, rdata0);
    end
    idle();
    step();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_clear_readback();
    test_basic();
    test_byte_enable();
    test_back_to_back();
    test_out_of_range();
    test_reset_mid_clear();
    test_cs_low();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
